// File: rtl/pc_fetch_ctrl.sv
// IF-stage program counter with next-PC select, stall hold and a multi-cycle
// post-branch flush. Define PC_BRANCH_COUNT_EN to add a saturating taken-branch counter.
module pc_fetch_ctrl #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_PC     = '0,
  parameter int               FLUSH_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             pc_src,
  input  logic [WIDTH-1:0] branch_target,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             flush,
  output logic             busy
`ifdef PC_BRANCH_COUNT_EN
  ,
  output logic [31:0]      branch_count
`endif
);

  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic [2:0]       CNT_INIT   = 3'(FLUSH_CYCLES - 1);
  localparam logic [WIDTH-1:0] ALIGN_MASK = {{(WIDTH-2){1'b1}}, 2'b00};
  localparam logic [WIDTH-1:0] PC_STEP    = WIDTH'(4);

  state_t           state, state_n;
  logic [2:0]       cnt, cnt_n;
  logic [WIDTH-1:0] pc_n;
  logic             flush_n, busy_n;
  logic             take_branch;

  // Overflow wraps naturally: the adder result is truncated to WIDTH.
  assign pc_plus4 = pc_out + PC_STEP;

  // Only a branch seen in RUN is real; in FLUSH it comes from a squashed instruction.
  assign take_branch = (state == RUN) && pc_src;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pc_n    = pc_out;
    flush_n = 1'b0;
    busy_n  = 1'b0;
    case (state)
      RUN: begin
        if (pc_src) begin
          pc_n    = branch_target & ALIGN_MASK;
          flush_n = 1'b1;
          cnt_n   = CNT_INIT;
          if (FLUSH_CYCLES > 1) begin
            state_n = FLUSH;
            busy_n  = 1'b1;
          end
        end else if (!stall) begin
          pc_n = pc_plus4;
        end
      end
      FLUSH: begin
        pc_n = pc_plus4;
        if (cnt != 3'd0) begin
          cnt_n   = cnt - 3'd1;
          flush_n = 1'b1;
          busy_n  = 1'b1;
        end else begin
          state_n = RUN;
        end
      end
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= RUN;
      cnt    <= 3'd0;
      pc_out <= RESET_PC;
      flush  <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      pc_out <= pc_n;
      flush  <= flush_n;
      busy   <= busy_n;
    end
  end

`ifdef PC_BRANCH_COUNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branch_count <= 32'd0;
    end else if (take_branch) begin
      branch_count <= sat_inc(branch_count);
    end
  end
`else
  logic unused_take_branch;
  assign unused_take_branch = take_branch;
`endif

endmodule
